// File: rtl/wheel_pkg.sv
// rtl/wheel_pkg.sv - shared FSM states, direction codes and helpers for wheel_speed_ctrl
package wheel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SNAP   = 2'd1,
    WINDOW = 2'd2,
    CALC   = 2'd3
  } state_t;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_CW   = 2'b01;
  localparam logic [1:0] DIR_CCW  = 2'b10;

  // Direction follows the sign of the modulo delta; the encoder flags play no part.
  function automatic logic [1:0] dir_of(input logic [7:0] d);
    if (d == 8'd0) begin
      return DIR_STOP;
    end else if (d[7]) begin
      return DIR_CCW;
    end else begin
      return DIR_CW;
    end
  endfunction

endpackage

// File: rtl/wheel_window_timer.sv
// rtl/wheel_window_timer.sv - window timer counting 0..WINDOW_CYCLES-2 with a one-cycle terminal pulse
module wheel_window_timer #(
  parameter int WINDOW_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tc
);

  // The WINDOW state spans WINDOW_CYCLES-1 cycles, so the last count is WINDOW_CYCLES-2.
  localparam int CW = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES - 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(WINDOW_CYCLES - 2);

  logic [CW-1:0] cnt_q;

  assign tc = run && (cnt_q == LAST);

  // Count while running; wrap to zero on terminal count so back-to-back windows line up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear || tc) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/wheel_speed_ctrl.sv
// rtl/wheel_speed_ctrl.sv - windowed encoder delta measurement; optional stall logic under WHEEL_STALL_DETECT_EN
module wheel_speed_ctrl
  import wheel_pkg::*;
#(
  parameter int WINDOW_CYCLES = 500000,
  parameter int STALL_WINDOWS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] count_in,
  input  logic       cw_in,
  input  logic       ccw_in,
  output logic [7:0] delta,
  output logic [1:0] direction,
  output logic       speed_valid,
  input  logic       speed_ready,
  output logic       stalled,
  output logic       overrun
);

  state_t     state_q;
  state_t     state_d;
  logic       timer_run;
  logic       timer_clear;
  logic       timer_tc;
  logic       load_result;
  logic       base_load;
  logic [7:0] base_q;
  logic [7:0] diff;
  logic [1:0] enc_flags_unused_q;

  // Modulo-256 subtraction absorbs counter wrap for moves up to +/-127 per window.
  assign diff = count_in - base_q;

  wheel_window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(timer_clear),
    .run  (timer_run),
    .tc   (timer_tc)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-state strobes; dropping enable wins over everything.
  always_comb begin
    state_d     = state_q;
    timer_run   = 1'b0;
    timer_clear = 1'b1;
    load_result = 1'b0;
    base_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = SNAP;
      end
      SNAP: begin
        base_load = 1'b1;
        state_d   = WINDOW;
      end
      WINDOW: begin
        timer_run   = 1'b1;
        timer_clear = 1'b0;
        if (timer_tc) state_d = CALC;
      end
      CALC: begin
        base_load   = 1'b1;
        load_result = enable;
        state_d     = WINDOW;
      end
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // Baseline sample taken at SNAP and at every CALC, exactly WINDOW_CYCLES apart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q <= 8'd0;
    end else if (base_load) begin
      base_q <= count_in;
    end
  end

  // Output register and valid/ready handshake; a new result may overwrite a pending one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      delta       <= 8'd0;
      direction   <= DIR_STOP;
      speed_valid <= 1'b0;
    end else if (load_result) begin
      delta       <= diff;
      direction   <= dir_of(diff);
      speed_valid <= 1'b1;
    end else if (speed_valid && speed_ready) begin
      speed_valid <= 1'b0;
    end
  end

  // Sticky overrun: set when a pending result is overwritten, cleared only in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (state_q == IDLE) begin
      overrun <= 1'b0;
    end else if (load_result && speed_valid && !speed_ready) begin
      overrun <= 1'b1;
    end
  end

  // Encoder flags captured alongside each result for debug visibility.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enc_flags_unused_q <= 2'b00;
    end else if (load_result) begin
      enc_flags_unused_q <= {ccw_in, cw_in};
    end
  end

`ifdef WHEEL_STALL_DETECT_EN
  logic [3:0] stall_cnt_q;

  // Saturating count of consecutive zero-delta windows; any motion restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 4'd0;
    end else if (state_q == IDLE) begin
      stall_cnt_q <= 4'd0;
    end else if (load_result) begin
      if (diff != 8'd0) begin
        stall_cnt_q <= 4'd0;
      end else if (stall_cnt_q != 4'hF) begin
        stall_cnt_q <= stall_cnt_q + 4'd1;
      end
    end
  end

  assign stalled = (stall_cnt_q >= 4'(STALL_WINDOWS));
`else
  localparam int STALL_WINDOWS_UNUSED = STALL_WINDOWS;
  assign stalled = 1'b0;
`endif

endmodule

// File: tb/tb_wheel_speed_ctrl.sv
// tb/tb_wheel_speed_ctrl.sv - table, scenario and random checks of wheel_speed_ctrl against a window-sampling model
module tb_wheel_speed_ctrl;

  localparam int W  = 16;
  localparam int SW = 4;
`ifdef WHEEL_STALL_DETECT_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] count_in = 8'd0;
  logic       cw_in = 1'b0;
  logic       ccw_in = 1'b0;
  logic       speed_ready = 1'b1;
  logic [7:0] delta;
  logic [1:0] direction;
  logic       speed_valid;
  logic       stalled;
  logic       overrun;

  wheel_speed_ctrl #(.WINDOW_CYCLES(W), .STALL_WINDOWS(SW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .count_in(count_in),
    .cw_in(cw_in), .ccw_in(ccw_in), .delta(delta), .direction(direction),
    .speed_valid(speed_valid), .speed_ready(speed_ready),
    .stalled(stalled), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: samples count every W edges counted from the edge after enable is seen.
  bit         m_idle = 1'b1;
  int         m_k = 0;
  logic [7:0] m_base = 8'd0;
  logic [7:0] m_delta = 8'd0;
  logic [1:0] m_dir = 2'b00;
  bit         m_valid = 1'b0;
  bit         m_ovr = 1'b0;
  int         m_zero = 0;

  typedef struct {
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] d;
    logic [1:0] dir;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_k = 0; m_base = 8'd0; m_delta = 8'd0; m_dir = 2'b00;
    m_valid = 1'b0; m_ovr = 1'b0; m_zero = 0;
  endtask

  task automatic model_edge();
    logic [7:0] d;
    bit sample;
    bit result;
    if (!reset) return;
    if (m_idle) begin
      if (m_valid && speed_ready) m_valid = 1'b0;
      m_ovr = 1'b0;
      m_zero = 0;
      if (enable) begin
        m_idle = 1'b0;
        m_k = 0;
      end
    end else begin
      m_k++;
      sample = (m_k == 1) || ((m_k - 1) % W == 0);
      result = (m_k > 1) && ((m_k - 1) % W == 0) && enable;
      if (result) begin
        d = count_in - m_base;
        if (m_valid && !speed_ready) m_ovr = 1'b1;
        m_delta = d;
        m_dir = (d == 8'd0) ? 2'b00 : ($signed(d) < 0 ? 2'b10 : 2'b01);
        m_valid = 1'b1;
        if (d == 8'd0) begin
          if (m_zero < 15) m_zero++;
        end else begin
          m_zero = 0;
        end
      end else if (m_valid && speed_ready) begin
        m_valid = 1'b0;
      end
      if (sample) m_base = count_in;
      if (!enable) m_idle = 1'b1;
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {3'b000, delta, direction, speed_valid, stalled, overrun};
  endfunction

  function automatic logic [15:0] model_vec();
    logic st;
    st = STALL_ON && (m_zero >= SW);
    return {3'b000, m_delta, m_dir, m_valid, st, m_ovr};
  endfunction

  // Each step: model update at the rising edge, full output compare at the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("cycle", dut_vec(), model_vec());
      #1;
    end
  endtask

  task automatic start(input logic [7:0] c0);
    enable = 1'b1;
    count_in = c0;
    step(2);
  endtask

  task automatic calc_window(input logic [7:0] c);
    step(W - 1);
    count_in = c;
    step(1);
  endtask

  task automatic stop();
    enable = 1'b0;
    step(2);
  endtask

  initial begin
    tbl[0] = '{c0: 8'd10,  c1: 8'd15,  d: 8'h05, dir: 2'b01};
    tbl[1] = '{c0: 8'd250, c1: 8'd4,   d: 8'h0A, dir: 2'b01};
    tbl[2] = '{c0: 8'd5,   c1: 8'd250, d: 8'hF5, dir: 2'b10};
    tbl[3] = '{c0: 8'd7,   c1: 8'd7,   d: 8'h00, dir: 2'b00};
    tbl[4] = '{c0: 8'd10,  c1: 8'd137, d: 8'h7F, dir: 2'b01};
    tbl[5] = '{c0: 8'd200, c1: 8'd73,  d: 8'h81, dir: 2'b10};
    tbl[6] = '{c0: 8'd0,   c1: 8'd128, d: 8'h80, dir: 2'b10};

    step(2);
    check("reset_outputs", dut_vec(), 16'h0000);
    reset = 1'b1;
    step(2);

    // Single-window vectors, including wrap and the +/-127 / -128 boundaries.
    for (int i = 0; i < 7; i++) begin
      start(tbl[i].c0);
      calc_window(tbl[i].c1);
      check("tbl_delta", 16'(delta), 16'(tbl[i].d));
      check("tbl_dir", 16'(direction), 16'(tbl[i].dir));
      check("tbl_valid", 16'(speed_valid), 16'd1);
      step(1);
      check("tbl_pulse", 16'(speed_valid), 16'd0);
      stop();
    end

    // Stall: five zero windows then a one-edge move.
    start(8'd50);
    for (int i = 1; i <= 5; i++) begin
      calc_window(8'd50);
      check("stall_delta", 16'(delta), 16'd0);
      check("stall_flag", 16'(stalled), 16'(STALL_ON && (i >= SW)));
    end
    calc_window(8'd51);
    check("stall_clear", 16'(stalled), 16'd0);
    check("stall_move", 16'(delta), 16'd1);
    stop();

    // Backpressure: +3 then +7 while not ready.
    speed_ready = 1'b0;
    start(8'd0);
    calc_window(8'd3);
    check("bp_first_ovr", 16'(overrun), 16'd0);
    calc_window(8'd10);
    check("bp_delta", 16'(delta), 16'd7);
    check("bp_overrun", 16'(overrun), 16'd1);
    check("bp_valid", 16'(speed_valid), 16'd1);
    speed_ready = 1'b1;
    step(1);
    check("bp_accept", 16'(speed_valid), 16'd0);
    check("bp_sticky", 16'(overrun), 16'd1);
    enable = 1'b0;
    step(1);
    check("bp_sticky_idle_entry", 16'(overrun), 16'd1);
    step(1);
    check("bp_cleared", 16'(overrun), 16'd0);

    // Disable mid-window: no result appears.
    start(8'd30);
    step(5);
    enable = 1'b0;
    count_in = 8'd40;
    step(W + 4);
    check("dis_no_result", 16'(speed_valid), 16'd0);

    // Disable in the CALC cycle: that result is discarded.
    start(8'd20);
    step(W - 1);
    enable = 1'b0;
    count_in = 8'd99;
    step(1);
    check("dis_calc_discard", 16'(speed_valid), 16'd0);
    step(2);

    // Pending result survives the return to IDLE.
    speed_ready = 1'b0;
    start(8'd20);
    calc_window(8'd25);
    step(3);
    enable = 1'b0;
    step(3);
    check("pend_valid", 16'(speed_valid), 16'd1);
    check("pend_delta", 16'(delta), 16'd5);
    speed_ready = 1'b1;
    step(1);
    check("pend_accept", 16'(speed_valid), 16'd0);

    // Asynchronous reset mid-window with a pending result.
    speed_ready = 1'b0;
    start(8'd1);
    calc_window(8'd9);
    step(4);
    reset = 1'b0;
    model_reset();
    #1;
    check("reset_mid", dut_vec(), 16'h0000);
    enable = 1'b0;
    #1;
    reset = 1'b1;
    step(3);
    check("reset_idle", 16'(speed_valid), 16'd0);

    // Randomized traffic against the model.
    speed_ready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      count_in = count_in + 8'($urandom_range(0, 20)) - 8'd10;
      cw_in = 1'($urandom_range(0, 1));
      ccw_in = ~cw_in;
      enable = ($urandom_range(0, 79) != 0);
      speed_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        reset = 1'b1;
      end
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
